// File: rtl/prog_loader.sv
// Boot-stream loader: 4-byte big-endian length header, then program bytes packed into
// little-endian 32-bit words written to instruction memory from address 0.
// Optional `PROG_LOADER_ACK_EN adds a one-byte completion acknowledge on a tx handshake.
module prog_loader #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned SIZE_BYTES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              load_err,
`ifdef PROG_LOADER_ACK_EN
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
`endif
  output logic [31:0]       byte_count
);

  typedef enum logic [1:0] {StSize, StData, StDone} state_e;

  localparam logic [32:0]       CapBytes = 33'(4) << ADDR_W;
  localparam logic [ADDR_W-1:0] AddrMax  = '1;
  localparam logic [1:0]        HdrLast  = 2'(SIZE_BYTES - 1);

  state_e            state_q, state_d;
  logic [31:0]       size_q, size_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              last_q, last_d;
  logic [31:0]       size_shift;
  logic [31:0]       word;
`ifdef PROG_LOADER_ACK_EN
  logic              tx_valid_q, tx_valid_d;
`endif

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    hdr_cnt_d  = hdr_cnt_q;
    buf_d      = buf_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    last_d     = last_q;
`ifdef PROG_LOADER_ACK_EN
    tx_valid_d = tx_valid_q;
`endif
    size_shift = {size_q[23:0], rx_data};
    word       = buf_q;
    word[{lane_q, 3'b000} +: 8] = rx_data;

    unique case (state_q)
      StSize: begin
        if (rx_valid) begin
          size_d = size_shift;
          if (hdr_cnt_q == HdrLast) begin
            hdr_cnt_d = '0;
            if (size_shift == 32'd0) begin
              state_d = StDone;
`ifdef PROG_LOADER_ACK_EN
              tx_valid_d = 1'b1;
`endif
            end else begin
              state_d = StData;
              if ({1'b0, size_shift} > CapBytes) err_d = 1'b1;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end
      end
      StData: begin
        // Address advances after each write; once the top word is written, memory is full.
        if (we_q) begin
          if (addr_q == AddrMax) full_d = 1'b1;
          else                   addr_d = addr_q + 1'b1;
        end
        if (last_q) begin
          state_d = StDone;
`ifdef PROG_LOADER_ACK_EN
          tx_valid_d = 1'b1;
`endif
        end else if (rx_valid) begin
          cnt_d = cnt_q + 32'd1;
          if (lane_q == 2'd3 || cnt_d == size_q) begin
            we_d    = ~full_d;
            wdata_d = word;
            buf_d   = '0;
            lane_d  = '0;
          end else begin
            buf_d  = word;
            lane_d = lane_q + 2'd1;
          end
          if (cnt_d == size_q) last_d = 1'b1;
        end
      end
      default: begin
`ifdef PROG_LOADER_ACK_EN
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StSize;
      size_q     <= '0;
      hdr_cnt_q  <= '0;
      buf_q      <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
`ifdef PROG_LOADER_ACK_EN
      tx_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      hdr_cnt_q  <= hdr_cnt_d;
      buf_q      <= buf_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      last_q     <= last_d;
`ifdef PROG_LOADER_ACK_EN
      tx_valid_q <= tx_valid_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = (state_q == StDone);
  assign load_err   = err_q;
  assign byte_count = cnt_q;
`ifdef PROG_LOADER_ACK_EN
  assign tx_valid   = tx_valid_q;
  assign tx_data    = err_q ? 8'hEE : 8'hAA;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-indexed reference model checked every cycle,
// plus literal expectations for the listed load scenarios.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel_b = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rstn_a, rstn_b;

  logic        a_we, a_done, a_err;
  logic [11:0] a_addr;
  logic [31:0] a_wdata, a_bc;
  logic        b_we, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_bc;

  logic        o_we, o_done, o_err;
  logic [11:0] o_addr;
  logic [31:0] o_wdata, o_bc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // The inactive instance is held in reset; both share the rx stream.
  assign rstn_a = rstn & ~sel_b;
  assign rstn_b = rstn & sel_b;

`ifdef PROG_LOADER_ACK_EN
  logic       tx_ready = 1'b1;
  logic       a_txv, b_txv, o_txv;
  logic [7:0] a_txd, b_txd, o_txd;
  assign o_txv = sel_b ? b_txv : a_txv;
  assign o_txd = sel_b ? b_txd : a_txd;
`endif

  prog_loader #(.ADDR_W(12), .SIZE_BYTES(4)) dut_a (
    .clk        (clk),
    .rstn       (rstn_a),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (a_we),
    .imem_addr  (a_addr),
    .imem_wdata (a_wdata),
    .load_done  (a_done),
    .load_err   (a_err),
`ifdef PROG_LOADER_ACK_EN
    .tx_valid   (a_txv),
    .tx_data    (a_txd),
    .tx_ready   (tx_ready),
`endif
    .byte_count (a_bc)
  );

  prog_loader #(.ADDR_W(2), .SIZE_BYTES(4)) dut_b (
    .clk        (clk),
    .rstn       (rstn_b),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (b_we),
    .imem_addr  (b_addr),
    .imem_wdata (b_wdata),
    .load_done  (b_done),
    .load_err   (b_err),
`ifdef PROG_LOADER_ACK_EN
    .tx_valid   (b_txv),
    .tx_data    (b_txd),
    .tx_ready   (tx_ready),
`endif
    .byte_count (b_bc)
  );

  assign o_we    = sel_b ? b_we    : a_we;
  assign o_addr  = sel_b ? 12'(b_addr) : a_addr;
  assign o_wdata = sel_b ? b_wdata : a_wdata;
  assign o_done  = sel_b ? b_done  : a_done;
  assign o_err   = sel_b ? b_err   : a_err;
  assign o_bc    = sel_b ? b_bc    : a_bc;

  // Reference model: works from byte indices, not lanes or state encodings.
  int          hdr_n, n, k, cap_words;
  logic [31:0] sz;
  logic        fin;
  logic [7:0]  prog [0:511];
  logic        exp_we, exp_done, exp_err, exp_acked;
  int          exp_addr;
  logic [31:0] exp_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_n = 0; n = 0; sz = '0; fin = 1'b0;
      exp_we = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_acked = 1'b0;
      exp_addr = 0; exp_data = '0;
    end else begin
      cap_words = sel_b ? 4 : 4096;
      exp_we = 1'b0;
`ifdef PROG_LOADER_ACK_EN
      if (exp_done && !exp_acked && tx_ready) exp_acked = 1'b1;
`endif
      if (exp_done) begin
      end else if (fin) begin
        exp_done = 1'b1;
      end else if (hdr_n < 4) begin
        if (rx_valid) begin
          sz = {sz[23:0], rx_data};
          hdr_n++;
          if (hdr_n == 4) begin
            if (sz == 0) exp_done = 1'b1;
            else if (longint'(sz) > 4 * longint'(cap_words)) exp_err = 1'b1;
          end
        end
      end else if (rx_valid) begin
        prog[n] = rx_data;
        n++;
        if (n % 4 == 0 || n == int'(sz)) begin
          k = (n - 1) / 4;
          if (k < cap_words) begin
            exp_we = 1'b1;
            exp_addr = k;
            exp_data = '0;
            for (int j = 0; j < 4; j++)
              if (4 * k + j < n) exp_data[8*j +: 8] = prog[4*k+j];
          end
        end
        if (n == int'(sz)) fin = 1'b1;
      end
    end
  end

  task automatic report(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];

  always @(negedge clk) begin
    report("cyc_we", 64'(o_we), 64'(exp_we));
    report("cyc_done", 64'(o_done), 64'(exp_done));
    report("cyc_err", 64'(o_err), 64'(exp_err));
    report("cyc_byte_count", 64'(o_bc), 64'(n));
    if (exp_we) begin
      report("cyc_addr", 64'(o_addr), 64'(exp_addr));
      report("cyc_wdata", 64'(o_wdata), 64'(exp_data));
    end
`ifdef PROG_LOADER_ACK_EN
    report("cyc_tx_valid", 64'(o_txv), 64'(exp_done && !exp_acked));
    if (exp_done && !exp_acked) report("cyc_tx_data", 64'(o_txd), exp_err ? 64'hEE : 64'hAA);
`endif
    if (o_we) begin
      wr_addr.push_back(o_addr);
      wr_data.push_back(o_wdata);
    end
  end

  task automatic drive(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic header(input logic [31:0] s, input int gap);
    for (int i = 3; i >= 0; i--) drive(s[8*i +: 8], gap);
  endtask

  task automatic do_reset(input logic use_b);
    rstn = 1'b0;
    sel_b = use_b;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!o_done && t < 20) begin @(posedge clk); #1; t++; end
    report(nm, 64'(o_done), 64'd1);
  endtask

  task automatic load_ramp(input logic [31:0] cnt);
    header(cnt, 1);
    for (int i = 0; i < int'(cnt); i++) drive(8'(i), i % 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t2 [6];
    logic [7:0] t4 [4];
    t2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    t4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // Reset values and a 108-byte load with mixed gaps, including back-to-back bytes.
    do_reset(1'b0);
    report("rst_done", 64'(o_done), 64'd0);
    report("rst_addr", 64'(o_addr), 64'd0);
    report("rst_wdata", 64'(o_wdata), 64'd0);
    load_ramp(32'd108);
    wait_done("t1_done");
    report("t1_nwrites", 64'(wr_addr.size()), 64'd27);
    if (wr_addr.size() == 27) begin
      report("t1_addr0", 64'(wr_addr[0]), 64'd0);
      report("t1_word0", 64'(wr_data[0]), 64'h03020100);
      report("t1_addr26", 64'(wr_addr[26]), 64'd26);
      report("t1_word26", 64'(wr_data[26]), 64'h6B6A6968);
    end
    report("t1_bc", 64'(o_bc), 64'd108);

    // Partial last word.
    do_reset(1'b0);
    header(32'd6, 1);
    foreach (t2[i]) drive(t2[i], 2);
    wait_done("t2_done");
    report("t2_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_data.size() == 2) begin
      report("t2_word0", 64'(wr_data[0]), 64'h44332211);
      report("t2_addr1", 64'(wr_addr[1]), 64'd1);
      report("t2_word1", 64'(wr_data[1]), 64'h00006655);
    end

    // Zero-length program finishes right after the header; later bytes are ignored.
    do_reset(1'b0);
    header(32'd0, 0);
    report("t3_done_now", 64'(o_done), 64'd1);
    drive(8'h5A, 0); drive(8'h5B, 0); drive(8'h5C, 3);
    report("t3_nwrites", 64'(wr_addr.size()), 64'd0);
    report("t3_bc", 64'(o_bc), 64'd0);

    // Eight back-to-back strobes.
    do_reset(1'b0);
    header(32'd4, 0);
    foreach (t4[i]) drive(t4[i], 0);
    wait_done("t4_done");
    report("t4_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_data.size() == 1) report("t4_word0", 64'(wr_data[0]), 64'hD4C3B2A1);

    // Overflow on a 4-word memory.
    do_reset(1'b1);
`ifdef PROG_LOADER_ACK_EN
    tx_ready = 1'b0;
`endif
    header(32'd20, 1);
    report("t5_err_hdr", 64'(o_err), 64'd1);
    for (int i = 0; i < 20; i++) drive(8'(8'h80 + i), i % 2);
    wait_done("t5_done");
    report("t5_nwrites", 64'(wr_addr.size()), 64'd4);
    if (wr_data.size() == 4) begin
      report("t5_addr3", 64'(wr_addr[3]), 64'd3);
      report("t5_word3", 64'(wr_data[3]), 64'h8F8E8D8C);
    end
    report("t5_bc", 64'(o_bc), 64'd20);
`ifdef PROG_LOADER_ACK_EN
    repeat (3) begin @(posedge clk); #1; end
    report("t5_txv_hold", 64'(o_txv), 64'd1);
    report("t5_txd", 64'(o_txd), 64'hEE);
    tx_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    report("t5_txv_drop", 64'(o_txv), 64'd0);
`endif

    // Asynchronous abort mid-load, then a fresh full load.
    do_reset(1'b0);
    header(32'd108, 0);
    drive(8'h00, 0); drive(8'h01, 0);
    #1 rstn = 1'b0;
    #1;
    report("t6_async_bc", 64'(o_bc), 64'd0);
    report("t6_async_addr", 64'(o_addr), 64'd0);
    report("t6_async_done", 64'(o_done), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    load_ramp(32'd108);
    wait_done("t6_done");
    report("t6_nwrites", 64'(wr_addr.size()), 64'd27);
    if (wr_data.size() == 27) begin
      report("t6_addr0", 64'(wr_addr[0]), 64'd0);
      report("t6_word0", 64'(wr_data[0]), 64'h03020100);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
